// File: rtl/prbs15_descrambler_checker.sv
// PRBS-15 (x^15+x^14+1) additive descrambler with a CC/DD/EE/FF pattern-lock
// checker, sticky lock flag and saturating post-lock error counter.
//
// state  | meaning
// EXP_CC | waiting for 8'hCC (frame start)
// EXP_DD | waiting for 8'hDD
// EXP_EE | waiting for 8'hEE
// EXP_FF | waiting for 8'hFF (frame end, counts a repetition)
module prbs15_descrambler_checker #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  input  logic [2:0] n,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic       data_flag,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    EXP_CC = 2'd0,
    EXP_DD = 2'd1,
    EXP_EE = 2'd2,
    EXP_FF = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [14:0] lfsr, lfsr_nxt;
  logic [7:0]  desc;
  logic [2:0]  rep, rep_nxt, rep_inc, n_eff;
  logic        flag_nxt;
  logic [7:0]  err_nxt;
  logic [7:0]  expected;
  logic        match;

  // Eight LFSR steps unrolled; bit i of the byte uses the feedback of step i.
  always_comb begin
    lfsr_nxt = lfsr;
    desc     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      desc[i]  = data_in[i] ^ (lfsr_nxt[14] ^ lfsr_nxt[13]);
      lfsr_nxt = {lfsr_nxt[13:0], lfsr_nxt[14] ^ lfsr_nxt[13]};
    end
  end

  assign n_eff   = (n == 3'd0) ? 3'd1 : n;
  assign rep_inc = rep + 3'd1;

  always_comb begin
    case (state)
      EXP_CC:  expected = 8'hCC;
      EXP_DD:  expected = 8'hDD;
      EXP_EE:  expected = 8'hEE;
      default: expected = 8'hFF;
    endcase
  end

  assign match = (desc == expected);

  always_comb begin
    state_nxt = state;
    rep_nxt   = rep;
    flag_nxt  = data_flag;
    err_nxt   = err_count;
    if (in_valid) begin
      if (match) begin
        case (state)
          EXP_CC:  state_nxt = EXP_DD;
          EXP_DD:  state_nxt = EXP_EE;
          EXP_EE:  state_nxt = EXP_FF;
          default: state_nxt = EXP_CC;
        endcase
        if (state == EXP_FF && !data_flag) begin
          rep_nxt = rep_inc;
          if (rep_inc == n_eff) flag_nxt = 1'b1;
        end
      end else begin
        state_nxt = (desc == 8'hCC) ? EXP_DD : EXP_CC;
        // Repetition counter is frozen once locked; errors only count after lock.
        if (!data_flag) rep_nxt = 3'd0;
        if (data_flag && err_count != 8'hFF) err_nxt = err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      state     <= EXP_CC;
      rep       <= 3'd0;
      data_out  <= 8'h00;
      out_valid <= 1'b0;
      data_flag <= 1'b0;
      err_count <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        lfsr     <= lfsr_nxt;
        data_out <= desc;
      end
      state     <= state_nxt;
      rep       <= rep_nxt;
      data_flag <= flag_nxt;
      err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prbs15_descrambler_checker.sv
// Directed bench for prbs15_descrambler_checker: hand-computed vectors plus a
// small independent scrambler model for the longer streams.
module tb_prbs15_descrambler_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       in_valid;
  logic [2:0] n;
  logic [7:0] data_out;
  logic       out_valid;
  logic       data_flag;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [14:0] m_s;
  logic [7:0]  pat [4];
  logic [7:0]  vec [4];
  logic [7:0]  sb;

  prbs15_descrambler_checker #(.SEED(15'h7FFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .n         (n),
    .data_out  (data_out),
    .out_valid (out_valid),
    .data_flag (data_flag),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic [7:0] d, input logic v, input logic r);
    data_in  = d;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    m_s = 15'h7FFF;
  endtask

  // Reference scrambler: same LFSR definition, written bit-serially.
  task automatic scramble(input logic [7:0] p, output logic [7:0] o);
    logic f;
    for (int i = 0; i < 8; i++) begin
      f    = m_s[14] ^ m_s[13];
      o[i] = p[i] ^ f;
      m_s  = {m_s[13:0], f};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, data_out, 8'h00);
    chk({tag, "_ovld"}, {7'd0, out_valid}, 8'h00);
    chk({tag, "_flag"}, {7'd0, data_flag}, 8'h00);
    chk({tag, "_err"},  err_count, 8'h00);
  endtask

  initial begin
    pat[0] = 8'hCC; pat[1] = 8'hDD; pat[2] = 8'hEE; pat[3] = 8'hFF;
    vec[0] = 8'hCC; vec[1] = 8'h9D; vec[2] = 8'hEE; vec[3] = 8'hCF;
    data_in = 8'h00; in_valid = 1'b0; rst = 1'b1; n = 3'd1;
    m_s = 15'h7FFF;

    drive(8'h00, 1'b0, 1'b1);
    do_reset();
    check_reset_outputs("reset");

    // Back-to-back known vectors, n=1
    n = 3'd1;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 1'b1, 1'b0);
      chk($sformatf("b2b_dout%0d", i), data_out, pat[i]);
      chk($sformatf("b2b_ovld%0d", i), {7'd0, out_valid}, 8'h01);
      chk($sformatf("b2b_flag%0d", i), {7'd0, data_flag}, (i == 3) ? 8'h01 : 8'h00);
    end
    drive(8'h5A, 1'b0, 1'b0);
    chk("idle_ovld", {7'd0, out_valid}, 8'h00);
    chk("idle_hold", data_out, 8'hFF);
    chk("idle_flag", {7'd0, data_flag}, 8'h01);

    // Same stream with 2-cycle gaps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 1'b1, 1'b0);
      chk($sformatf("gap_dout%0d", i), data_out, pat[i]);
      chk($sformatf("gap_flag%0d", i), {7'd0, data_flag}, (i == 3) ? 8'h01 : 8'h00);
      for (int g = 0; g < 2; g++) begin
        drive(8'hA5, 1'b0, 1'b0);
        chk($sformatf("gap_ovld%0d_%0d", i, g), {7'd0, out_valid}, 8'h00);
        chk($sformatf("gap_hold%0d_%0d", i, g), data_out, pat[i]);
      end
    end

    // n=2 loopback through the model
    do_reset();
    n = 3'd2;
    for (int i = 0; i < 8; i++) begin
      scramble(pat[i % 4], sb);
      drive(sb, 1'b1, 1'b0);
      chk($sformatf("n2_dout%0d", i), data_out, pat[i % 4]);
      if (i == 3) chk("n2_flag_after4", {7'd0, data_flag}, 8'h00);
      if (i == 7) chk("n2_flag_after8", {7'd0, data_flag}, 8'h01);
    end
    chk("n2_err_locked", err_count, 8'h00);

    // Three single-bit corruptions after lock
    for (int i = 0; i < 3; i++) begin
      scramble(pat[i], sb);
      drive(sb ^ (8'h01 << i), 1'b1, 1'b0);
    end
    chk("err3_count", err_count, 8'h03);
    chk("err3_flag", {7'd0, data_flag}, 8'h01);

    // 300 further bad bytes saturate the counter
    for (int i = 0; i < 300; i++) begin
      scramble(8'h00, sb);
      drive(sb, 1'b1, 1'b0);
      if (i == 251) chk("err_at_255", err_count, 8'hFF);
    end
    chk("err_sat", err_count, 8'hFF);
    chk("err_sat_flag", {7'd0, data_flag}, 8'h01);

    // Mismatches before lock leave err_count alone
    do_reset();
    n = 3'd1;
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h34, 1'b1, 1'b0);
    chk("prelock_err", err_count, 8'h00);
    chk("prelock_flag", {7'd0, data_flag}, 8'h00);

    // Lock, start a second frame, reset mid-frame with in_valid high
    do_reset();
    n = 3'd1;
    for (int i = 0; i < 4; i++) begin
      scramble(pat[i], sb);
      drive(sb, 1'b1, 1'b0);
    end
    chk("mid_locked", {7'd0, data_flag}, 8'h01);
    scramble(pat[0], sb);
    drive(sb, 1'b1, 1'b0);
    scramble(pat[1], sb);
    drive(sb, 1'b1, 1'b0);
    scramble(pat[2], sb);
    drive(sb, 1'b1, 1'b1);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 1'b1, 1'b0);
      chk($sformatf("resend_dout%0d", i), data_out, pat[i]);
      chk($sformatf("resend_flag%0d", i), {7'd0, data_flag}, (i == 3) ? 8'h01 : 8'h00);
    end

    // n=0 behaves as n=1
    do_reset();
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 1'b1, 1'b0);
      chk($sformatf("n0_dout%0d", i), data_out, pat[i]);
      chk($sformatf("n0_flag%0d", i), {7'd0, data_flag}, (i == 3) ? 8'h01 : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
